// File: rtl/br_flow_serializer_if.sv
// Push/pop handshake bundle for br_flow_serializer: wide packets in, narrow tagged flits out.
// Latency: none (wires only).
// Backpressure: push_ready/pop_ready follow the usual valid-ready rules.
// Ports: push_valid/push_ready/push_data (packet side), pop_valid/pop_ready/pop_data/pop_id/pop_last
// (flit side). slave = serializer view, master = the environment driving packets and taking flits.
interface br_flow_serializer_if #(
    parameter int PushWidth = 2,
    parameter int PopWidth  = 1
);
    localparam int NumPopFlits    = PushWidth / PopWidth;
    localparam int PopFlitIdWidth = (NumPopFlits > 1) ? $clog2(NumPopFlits) : 1;

    logic                      push_ready;
    logic                      push_valid;
    logic [PushWidth-1:0]      push_data;
    logic                      pop_ready;
    logic                      pop_valid;
    logic [PopWidth-1:0]       pop_data;
    logic [PopFlitIdWidth-1:0] pop_id;
    logic                      pop_last;

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, pop_id, pop_last
    );

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, pop_id, pop_last
    );
endinterface

// File: rtl/br_flow_serializer.sv
// Splits each PushWidth packet into NumPopFlits PopWidth flits tagged with pop_id/pop_last.
// Latency: first flit valid 1 cycle after push acceptance; 1 flit/cycle, no bubble between packets.
// Backpressure: push_ready only when empty or the last flit pops this cycle; pop side holds under !pop_ready.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of br_flow_serializer_if).
module br_flow_serializer #(
    parameter int PushWidth                     = 2,
    parameter int PopWidth                      = 1,
    parameter bit SerializeMostSignificantFirst = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    br_flow_serializer_if.slave bus
);
    localparam int NumPopFlits    = PushWidth / PopWidth;
    localparam int PopFlitIdWidth = (NumPopFlits > 1) ? $clog2(NumPopFlits) : 1;
    localparam logic [PopFlitIdWidth-1:0] LastId = PopFlitIdWidth'(NumPopFlits - 1);

    if ((PopWidth < 1) || (PushWidth <= PopWidth) || ((PushWidth % PopWidth) != 0)) begin : g_bad_widths
        $error("br_flow_serializer: PushWidth must exceed and be a multiple of PopWidth");
    end

    typedef enum logic {
        EMPTY   = 1'b0,
        SENDING = 1'b1
    } state_t;

    state_t                    state;
    logic [PushWidth-1:0]      hold;
    logic [PopFlitIdWidth-1:0] cnt;
    logic [PopFlitIdWidth-1:0] cnt_nxt;
    logic                      pop_valid_q;
    logic                      pop_last_q;
    logic [PopWidth-1:0]       flit;
    logic                      pop_hs;
    logic                      push_ready_c;
    logic                      push_hs;

    assign cnt_nxt      = cnt + 1'b1;
    assign pop_hs       = pop_valid_q && bus.pop_ready;
    // Accepting alongside the last pop keeps the output streaming with no idle cycle.
    // Held low during reset so nothing is accepted while the block is being cleared.
    assign push_ready_c = rst_n && ((state == EMPTY) || (pop_hs && pop_last_q));
    assign push_hs      = push_ready_c && bus.push_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            cnt         <= '0;
            pop_valid_q <= 1'b0;
            pop_last_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push_hs) begin
                        hold        <= bus.push_data;
                        cnt         <= '0;
                        state       <= SENDING;
                        pop_valid_q <= 1'b1;
                        pop_last_q  <= (LastId == '0);
                    end
                end
                SENDING: begin
                    if (pop_hs) begin
                        if (!pop_last_q) begin
                            cnt        <= cnt_nxt;
                            pop_last_q <= (cnt_nxt == LastId);
                        end else if (push_hs) begin
                            hold        <= bus.push_data;
                            cnt         <= '0;
                            pop_valid_q <= 1'b1;
                            pop_last_q  <= (LastId == '0);
                        end else begin
                            state       <= EMPTY;
                            cnt         <= '0;
                            pop_valid_q <= 1'b0;
                            pop_last_q  <= 1'b0;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Flit k of the held packet; counter never exceeds LastId so one slice always matches.
    always_comb begin
        flit = '0;
        for (int k = 0; k < NumPopFlits; k++) begin
            if (cnt == PopFlitIdWidth'(k)) begin
                if (SerializeMostSignificantFirst) begin
                    flit = hold[PushWidth-1-k*PopWidth -: PopWidth];
                end else begin
                    flit = hold[k*PopWidth +: PopWidth];
                end
            end
        end
    end

    assign bus.push_ready = push_ready_c;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.pop_data   = flit;
    assign bus.pop_id     = cnt;
    assign bus.pop_last   = pop_last_q;

    // Upstream must hold an unaccepted packet steady.
    a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid && !push_ready_c |=> bus.push_valid && $stable(bus.push_data));
    c_push_backpressure: cover property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid && !push_ready_c);

    a_last_valid: assert property (@(posedge clk) disable iff (!rst_n)
        pop_last_q |-> pop_valid_q);
    a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(cnt) < NumPopFlits);
    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
        pop_valid_q && !bus.pop_ready |=>
            pop_valid_q && $stable(flit) && $stable(cnt) && $stable(pop_last_q));
    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        push_ready_c && (state != EMPTY) |-> pop_last_q && bus.pop_ready);
endmodule

// File: tb/tb_br_flow_serializer.sv
// Bench for br_flow_serializer: 32/8 MSB-first, 32/8 LSB-first and 24/8 MSB-first instances.
// Latency: n/a.
// Backpressure: bench drives pop_ready directly, including random stalls on the 24-bit instance.
module tb_br_flow_serializer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        pv;
    logic        pr;
    logic [31:0] pd;
    logic        pv_w;
    logic        pr_w;
    logic [23:0] pd_w;

    always #5 clk = ~clk;

    br_flow_serializer_if #(.PushWidth(32), .PopWidth(8)) if_m ();
    br_flow_serializer_if #(.PushWidth(32), .PopWidth(8)) if_l ();
    br_flow_serializer_if #(.PushWidth(24), .PopWidth(8)) if_w ();

    assign if_m.push_valid = pv && !sel;
    assign if_m.push_data  = pd;
    assign if_m.pop_ready  = pr;
    assign if_l.push_valid = pv && sel;
    assign if_l.push_data  = pd;
    assign if_l.pop_ready  = pr;
    assign if_w.push_valid = pv_w;
    assign if_w.push_data  = pd_w;
    assign if_w.pop_ready  = pr_w;

    br_flow_serializer #(.PushWidth(32), .PopWidth(8), .SerializeMostSignificantFirst(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(if_m));
    br_flow_serializer #(.PushWidth(32), .PopWidth(8), .SerializeMostSignificantFirst(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(if_l));
    br_flow_serializer #(.PushWidth(24), .PopWidth(8), .SerializeMostSignificantFirst(1'b1)) u_w24 (
        .clk(clk), .rst_n(rst_n), .bus(if_w));

    // Selected 32-bit instance as seen by the directed tests.
    logic       o_pv;
    logic       o_last;
    logic       o_prdy;
    logic [7:0] o_data;
    logic [1:0] o_id;
    assign o_pv   = sel ? if_l.pop_valid  : if_m.pop_valid;
    assign o_last = sel ? if_l.pop_last   : if_m.pop_last;
    assign o_prdy = sel ? if_l.push_ready : if_m.push_ready;
    assign o_data = sel ? if_l.pop_data   : if_m.pop_data;
    assign o_id   = sel ? if_l.pop_id     : if_m.pop_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pkt;
        logic        lsb;
        logic [31:0] exp_seq;   // expected flits in output order, first flit in [31:24]
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1. Pushes one packet and checks all four flits.
    task automatic send_pkt(input logic [31:0] pkt, input logic lsb, input logic [31:0] exp_seq,
                            input string tag);
        logic [7:0] ef;
        sel = lsb;
        pr  = 1'b1;
        pv  = 1'b1;
        pd  = pkt;
        @(negedge clk);
        chk({tag, " idle pop_valid"}, o_pv, 0);
        chk({tag, " idle push_ready"}, o_prdy, 1);
        tick;
        pv = 1'b0;
        pd = '0;
        for (int k = 0; k < 4; k++) begin
            ef = exp_seq[31-8*k -: 8];
            @(negedge clk);
            chk($sformatf("%s flit%0d valid", tag, k), o_pv, 1);
            chk($sformatf("%s flit%0d data", tag, k), o_data, ef);
            chk($sformatf("%s flit%0d id", tag, k), o_id, k);
            chk($sformatf("%s flit%0d last", tag, k), o_last, (k == 3));
            chk($sformatf("%s flit%0d push_ready", tag, k), o_prdy, (k == 3));
            tick;
        end
        @(negedge clk);
        chk({tag, " drained pop_valid"}, o_pv, 0);
        tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] seq;
        logic [9:0]  q [$];
        logic [9:0]  exp;
        int          issued;
        int          acc_cnt;
        logic        acc;

        vecs[0] = '{32'hBAADF00D, 1'b0, 32'hBAADF00D};
        vecs[1] = '{32'hBAADF00D, 1'b1, 32'h0DF0ADBA};
        vecs[2] = '{32'h12345678, 1'b0, 32'h12345678};
        vecs[3] = '{32'h12345678, 1'b1, 32'h78563412};
        vecs[4] = '{32'h00FF807F, 1'b1, 32'h7F80FF00};

        rst_n = 1'b0;
        sel   = 1'b0;
        pv    = 1'b0;
        pr    = 1'b0;
        pd    = '0;
        pv_w  = 1'b0;
        pr_w  = 1'b0;
        pd_w  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst pop_valid", if_m.pop_valid, 0);
        chk("rst pop_id", if_m.pop_id, 0);
        chk("rst pop_last", if_m.pop_last, 0);
        chk("rst push_ready", if_m.push_ready, 0);
        chk("rst w24 push_ready", if_w.push_ready, 0);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst push_ready", if_m.push_ready, 1);
        chk("post rst pop_valid", if_m.pop_valid, 0);
        tick;

        // Table-driven single packets, MSB and LSB first
        for (int i = 0; i < 5; i++) begin
            send_pkt(vecs[i].pkt, vecs[i].lsb, vecs[i].exp_seq, $sformatf("vec%0d", i));
        end

        // Back-to-back packets, no bubble
        sel = 1'b0;
        pr  = 1'b1;
        pv  = 1'b1;
        pd  = 32'h01234567;
        seq = 64'h0123456789ABCDEF;
        @(negedge clk);
        tick;
        pd = 32'h89ABCDEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b flit%0d valid", i), o_pv, 1);
            chk($sformatf("b2b flit%0d data", i), o_data, seq[63-8*i -: 8]);
            chk($sformatf("b2b flit%0d id", i), o_id, i % 4);
            chk($sformatf("b2b flit%0d last", i), o_last, ((i % 4) == 3));
            if (i <= 3) chk($sformatf("b2b flit%0d push_ready", i), o_prdy, (i == 3));
            tick;
            if (i == 3) pv = 1'b0;
        end
        @(negedge clk);
        chk("b2b drained", o_pv, 0);
        tick;

        // Backpressure at id 2
        pv = 1'b1;
        pd = 32'hBAADF00D;
        @(negedge clk);
        tick;
        pv = 1'b0;
        @(negedge clk);
        chk("bp id0 data", o_data, 8'hBA);
        tick;
        @(negedge clk);
        chk("bp id1 data", o_data, 8'hAD);
        tick;
        pr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp stall%0d valid", i), o_pv, 1);
            chk($sformatf("bp stall%0d data", i), o_data, 8'hF0);
            chk($sformatf("bp stall%0d id", i), o_id, 2);
            chk($sformatf("bp stall%0d last", i), o_last, 0);
            chk($sformatf("bp stall%0d push_ready", i), o_prdy, 0);
            tick;
        end
        pr = 1'b1;
        @(negedge clk);
        chk("bp resume data", o_data, 8'hF0);
        chk("bp resume id", o_id, 2);
        tick;
        @(negedge clk);
        chk("bp last data", o_data, 8'h0D);
        chk("bp last flag", o_last, 1);
        tick;
        @(negedge clk);
        chk("bp drained", o_pv, 0);
        tick;

        // Reset mid-packet
        pv = 1'b1;
        pd = 32'h11223344;
        @(negedge clk);
        tick;
        pv = 1'b0;
        @(negedge clk);
        chk("mrst id0 data", o_data, 8'h11);
        tick;
        @(negedge clk);
        chk("mrst id1 id", o_id, 1);
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst pop_valid", o_pv, 0);
        chk("mrst pop_id", o_id, 0);
        chk("mrst pop_last", o_last, 0);
        chk("mrst push_ready", o_prdy, 1);
        tick;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("mrst idle%0d pop_valid", i), o_pv, 0);
            tick;
        end
        send_pkt(32'hCAFEF00D, 1'b0, 32'hCAFEF00D, "after_rst");

        // 24/8 random ready/valid with scoreboard
        issued  = 0;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 20000 && !(issued == 1000 && !pv_w && q.size() == 0); cyc++) begin
            @(negedge clk);
            if (if_w.pop_valid && pr_w) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL w24 spurious flit: got %0h want none", if_w.pop_data);
                end else begin
                    exp = q.pop_front();
                    chk("w24 flit {last,id,data}",
                        {if_w.pop_last, if_w.pop_id, if_w.pop_data},
                        {(exp[9:8] == 2'd2), exp});
                end
            end
            acc = pv_w && if_w.push_ready;
            if (acc) begin
                acc_cnt++;
                for (int k = 0; k < 3; k++) begin
                    q.push_back({2'(k), pd_w[23-8*k -: 8]});
                end
            end
            @(posedge clk);
            #1;
            pr_w = ($urandom_range(0, 3) != 0);
            if (acc || !pv_w) begin
                if (issued < 1000 && $urandom_range(0, 3) != 0) begin
                    pv_w = 1'b1;
                    pd_w = 24'($urandom);
                    issued++;
                end else begin
                    pv_w = 1'b0;
                end
            end
        end
        chk("w24 packets accepted", acc_cnt, 1000);
        chk("w24 scoreboard empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
